lock_ctrl: RTL and testbench
============================

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter CODE, default 4'b1010: unlock code compared against sw.
REQ-002 Parameter MAX_TRIES, default 3: consecutive wrong entries that trigger ERR (legal range 1..7).
REQ-003 Parameter DEBOUNCE_CYCLES, default 500_000: button stable time, 10 ms at 50 MHz.
REQ-004 Parameter OPEN_CYCLES, default 250_000_000: OPEN dwell time, 5 s at 50 MHz.
REQ-005 Parameter LOCK_CYCLES, default 500_000_000: ERR lockout time, 10 s at 50 MHz.
REQ-006 Port clk, input, 1: 50 MHz system clock; the block uses this single clock.
REQ-007 Port rst, input, 1: reset, asynchronous and active-high.
REQ-008 Port sw, input, 4: code switches; asynchronous, level-sampled.
REQ-009 Port btn_enter, input, 1: raw enter pushbutton, active-high, bouncy.
REQ-010 Port btn_power, input, 1: raw power pushbutton, active-high, bouncy.
REQ-011 Port state, output, 3: display message code (001 Err, 010 On, 011 OFF, 100 OPEn); registered.
REQ-012 Port buzz, output, 1: single-cycle buzzer trigger; the display side stretches it.

Function
REQ-013 Each button shall pass through a 2-FF synchronizer, then a debouncer; a press shall be accepted when the synchronized level is held high for DEBOUNCE_CYCLES consecutive cycles, producing exactly one 1-cycle press pulse per press.
REQ-014 Press pulse latency after the input settles high shall be 2 + DEBOUNCE_CYCLES cycles (±1); any bounce shall restart the count, and release shall require the same stable time before re-arm.
REQ-015 The FSM shall have exactly four states: OFF=3'b011, ON=3'b010, OPEN=3'b100, ERR=3'b001; state shall always equal the FSM register, and 3'b000 shall never appear.
REQ-016 OFF: a power press shall go to ON, clearing the try counter; an enter press shall be ignored.
REQ-017 ON: a power press shall go to OFF.
REQ-018 ON: an enter press with sw==CODE, with sw sampled in the pulse cycle, shall go to OPEN and clear the try counter.
REQ-019 ON: an enter press with sw!=CODE shall increment the try counter; if the counter reaches MAX_TRIES, the FSM shall go to ERR and clear the counter.
REQ-020 OPEN: the FSM shall return to ON after exactly OPEN_CYCLES cycles; a power press shall go to OFF immediately; an enter press shall be ignored.
REQ-021 ERR: a power press shall go to OFF; an enter press shall be ignored; the exit on timeout is per REQ-028/029.
REQ-022 buzz shall be high for exactly one cycle, the cycle after any transition into ERR; it shall be low otherwise.
REQ-023 A power press and an enter press in the same cycle: power shall win and enter shall be discarded.
REQ-024 The dwell timer shall be 29 bits, cleared on every state change, and shall not wrap; it shall saturate at its terminal count.
REQ-025 The try counter shall be 3 bits and shall be cleared on every entry to OFF, OPEN or ERR.

Reset
REQ-026 While rst is high: state=OFF (3'b011), buzz=0, try counter=0, timer=0, debouncers idle with press pulses low.
REQ-027 A reset asserted mid-OPEN or mid-ERR shall abort the dwell with no buzz; a button held through reset release shall require the full DEBOUNCE_CYCLES before it is accepted.

Configuration
REQ-028 With LOCK_LOCKOUT_EN defined, ERR shall return to ON automatically after exactly LOCK_CYCLES cycles.
REQ-029 Without LOCK_LOCKOUT_EN, ERR shall persist until a power press or reset, LOCK_CYCLES shall be unused, and the timer shall be idle in ERR.

Structure
REQ-030 A shared package lock_pkg shall hold the four state encodings and the default values of CODE and MAX_TRIES; the display driver shall import the same encodings.
REQ-031 One sub-module btn_debounce (synchronizer, stable counter, rising-edge pulse, parameter DEBOUNCE_CYCLES) shall be instantiated twice.

Verification
REQ-032 The bench shall run with DEBOUNCE_CYCLES=4, OPEN_CYCLES=20, LOCK_CYCLES=30 and cover these scenarios:
- Reset then power press -> state 011 then 010; buzz stays 0.
- In ON, sw=1010 then enter -> state 100 for exactly 20 cycles, then 010.
- In ON, three presses with sw=0000 -> third press gives state 001 and one buzz pulse; with LOCK_LOCKOUT_EN, state 010 30 cycles later; without it, 001 holds until a power press, then 011.
- Enter line toggling every 2 cycles for 40 cycles, then held for 10 cycles -> exactly one press is accepted.
- Power and enter presses in the same cycle while in ON with the correct code -> state 011; not OPEN.
- rst asserted 10 cycles into OPEN -> state 011 asynchronously; buzz 0; try counter 0 (two wrong entries after resume do not reach ERR).

Source files
------------

// File: rtl/lock_pkg.sv
// Shared state encodings and defaults for the lock controller and its display driver.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_ERR  = 3'b001,
        ST_ON   = 3'b010,
        ST_OFF  = 3'b011,
        ST_OPEN = 3'b100
    } lock_state_e;

    localparam logic [3:0]  DEFAULT_CODE      = 4'b1010;
    localparam int unsigned DEFAULT_MAX_TRIES = 3;
    localparam int unsigned TIMER_W           = 29;

    // Last timer value of a dwell lasting `cycles` clocks.
    function automatic logic [TIMER_W-1:0] dwell_last(input int unsigned cycles);
        return (cycles > 0) ? TIMER_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer and one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The count only runs while the synchronized level differs from the accepted one,
    // so any bounce restarts it, and release needs the same stable time as press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt    <= '0;
                r_stable <= r_sync[1];
                r_press  <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/lock_ctrl.sv
// Combination-lock controller with OFF/ON/OPEN/ERR states.
// Define LOCK_LOCKOUT_EN to make ERR return to ON after LOCK_CYCLES.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [3:0]  CODE            = DEFAULT_CODE,
    parameter int unsigned MAX_TRIES       = DEFAULT_MAX_TRIES,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned OPEN_CYCLES     = 250_000_000,
    parameter int unsigned LOCK_CYCLES     = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_power,
    output logic [2:0] state,
    output logic       buzz
);

    localparam logic [2:0]         TRIES_LAST = 3'(MAX_TRIES - 1);
    localparam logic [TIMER_W-1:0] OPEN_LAST  = dwell_last(OPEN_CYCLES);
    // Saturation point covers the longest dwell so the timer can never wrap.
    localparam logic [TIMER_W-1:0] TIMER_SAT  =
        dwell_last((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES);
`ifdef LOCK_LOCKOUT_EN
    localparam logic [TIMER_W-1:0] LOCK_LAST  = dwell_last(LOCK_CYCLES);
`endif

    logic w_enter;
    logic w_power;
    logic w_timer_run;

    lock_state_e        r_state;
    lock_state_e        w_next;
    logic [2:0]         r_tries;
    logic [TIMER_W-1:0] r_timer;
    logic               r_buzz;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (btn_enter),
        .o_press (w_enter)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_power (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_btn   (btn_power),
        .o_press (w_power)
    );

`ifdef LOCK_LOCKOUT_EN
    assign w_timer_run = (r_state == ST_OPEN) || (r_state == ST_ERR);
`else
    assign w_timer_run = (r_state == ST_OPEN);
`endif

    // Power is tested first in every state so it always wins over enter.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_power) w_next = ST_ON;
            end
            ST_ON: begin
                if (w_power) begin
                    w_next = ST_OFF;
                end else if (w_enter) begin
                    if (sw == CODE)              w_next = ST_OPEN;
                    else if (r_tries == TRIES_LAST) w_next = ST_ERR;
                end
            end
            ST_OPEN: begin
                if (w_power)                   w_next = ST_OFF;
                else if (r_timer == OPEN_LAST) w_next = ST_ON;
            end
            ST_ERR: begin
                if (w_power) w_next = ST_OFF;
`ifdef LOCK_LOCKOUT_EN
                else if (r_timer == LOCK_LAST) w_next = ST_ON;
`endif
            end
            default: w_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_tries <= '0;
            r_timer <= '0;
            r_buzz  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_buzz  <= (w_next == ST_ERR) && (r_state != ST_ERR);
            if (w_next != r_state) begin
                r_timer <= '0;
                r_tries <= '0;
            end else begin
                if (w_timer_run && (r_timer != TIMER_SAT)) r_timer <= r_timer + 1'b1;
                if ((r_state == ST_ON) && w_enter && !w_power && (sw != CODE))
                    r_tries <= r_tries + 1'b1;
            end
        end
    end

    assign state = r_state;
    assign buzz  = r_buzz;

endmodule

// File: tb/tb_lock_ctrl.sv
// Scoreboard bench for lock_ctrl: a behavioural model queues expected display events,
// a monitor pops and compares them whenever the display state changes or buzz fires.
module tb_lock_ctrl;

    localparam int         D     = 4;
    localparam int         OPENC = 20;
    localparam int         LOCKC = 30;
    localparam int         MAXT  = 3;
    localparam logic [3:0] KEY   = 4'b1010;
    localparam logic [2:0] S_ERR = 3'b001, S_ON = 3'b010, S_OFF = 3'b011, S_OPEN = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_power = 1'b0;
    logic [2:0] state;
    logic       buzz;

    always #5 clk = ~clk;

    lock_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .OPEN_CYCLES     (OPENC),
        .LOCK_CYCLES     (LOCKC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_power (btn_power),
        .state     (state),
        .buzz      (buzz)
    );

    typedef struct {
        logic [2:0] st;
        logic       bz;
        int         dwell;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_total++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, req);
    endtask

    // ---------------- monitor ----------------
    logic [2:0] prev_st = S_OFF;
    bit         mon_en  = 1'b0;
    int         cyc     = 0;
    int         last_evt = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && !rst) begin
            cyc++;
            if (state !== prev_st || buzz !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got state=%b buzz=%b required no event", state, buzz);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_state"}, 32'(state), 32'(e.st));
                    check({e.name, "_buzz"}, 32'(buzz), 32'(e.bz));
                    if (e.dwell > 0) check({e.name, "_dwell"}, cyc - last_evt, e.dwell);
                end
                last_evt = cyc;
            end
            prev_st = state;
        end
    end

    // ---------------- reference model ----------------
    logic [2:0] m_st    = S_OFF;
    int         m_tries = 0;
    int         m_wait  = 0;

    task automatic expect_evt(input logic [2:0] s, input logic b, input int d, input string n);
        exp_q.push_back('{st: s, bz: b, dwell: d, name: n});
    endtask

    task automatic model_power();
        m_wait = 0;
        if (m_st == S_OFF) begin
            m_st = S_ON;
            expect_evt(S_ON, 1'b0, 0, "power_on");
        end else begin
            m_st = S_OFF;
            expect_evt(S_OFF, 1'b0, 0, "power_off");
        end
        m_tries = 0;
    endtask

    task automatic model_enter(input logic [3:0] s);
        m_wait = 0;
        if (m_st != S_ON) return;
        if (s == KEY) begin
            expect_evt(S_OPEN, 1'b0, 0, "open");
            expect_evt(S_ON, 1'b0, OPENC, "open_timeout");
            m_tries = 0;
            m_wait  = OPENC + 5;
        end else begin
            m_tries++;
            if (m_tries == MAXT) begin
                m_tries = 0;
                expect_evt(S_ERR, 1'b1, 0, "err_entry");
`ifdef LOCK_LOCKOUT_EN
                expect_evt(S_ON, 1'b0, LOCKC, "lockout_end");
                m_wait = LOCKC + 5;
`else
                m_st = S_ERR;
`endif
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pw, input bit en);
        btn_power = pw;
        btn_enter = en;
    endtask

    task automatic press(input bit pw, input bit en, input int bounces);
        for (int i = 0; i < bounces; i++) begin
            drive(pw, en);   step($urandom_range(1, 3));
            drive(0, 0);     step($urandom_range(1, 3));
        end
        drive(pw, en);
        step(D + 6);
        for (int i = 0; i < bounces; i++) begin
            drive(0, 0);     step($urandom_range(1, 3));
            drive(pw, en);   step($urandom_range(1, 3));
        end
        drive(0, 0);
        step(D + 6);
    endtask

    task automatic do_op(input bit pw, input bit en, input logic [3:0] s, input int bounces);
        sw = s;
        if (pw) model_power();
        else if (en) model_enter(s);
        press(pw, en, bounces);
        step(m_wait);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        step(3);
        check("reset_state", 32'(state), 32'(S_OFF));
        check("reset_buzz", 32'(buzz), 32'(0));
        #2 rst = 1'b0;
        prev_st = S_OFF;
        mon_en  = 1'b1;
        step(2);

        // power on, correct code, OPEN dwell
        do_op(1, 0, 4'h0, 0);
        do_op(0, 1, KEY, 1);

        // three wrong entries -> ERR, then power off
        for (int i = 0; i < 3; i++) do_op(0, 1, 4'h0, 2);
        do_op(0, 1, 4'h0, 0);
        do_op(1, 0, 4'h0, 0);

        // chattering enter: exactly one accepted; two more wrong ones then reach ERR
        do_op(1, 0, 4'h0, 0);
        sw = 4'h0;
        model_enter(4'h0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1); step(2);
            drive(0, 0); step(2);
        end
        drive(0, 1); step(10);
        drive(0, 0); step(D + 6);
        do_op(0, 1, 4'h0, 0);
        do_op(0, 1, 4'h5, 0);
        do_op(1, 0, 4'h0, 0);

        // power and enter in the same cycle with the right code
        do_op(1, 0, 4'h0, 0);
        sw = KEY;
        model_power();
        press(1, 1, 0);

        // reset in the middle of OPEN
        do_op(1, 0, 4'h0, 0);
        sw = KEY;
        model_enter(KEY);
        drive(0, 1);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            step(1);
            if (state === S_OPEN) seen = 1'b1;
        end
        check("open_before_reset", 32'(seen), 32'(1));
        drive(0, 0);
        step(10);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        expect_evt(S_OFF, 1'b0, 0, "reset_in_open");
        #2 rst = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 32'(S_OFF));
        check("async_reset_buzz", 32'(buzz), 32'(0));
        step(3);
        #2 rst = 1'b0;
        m_st    = S_OFF;
        m_tries = 0;
        step(D + 6);
        do_op(1, 0, 4'h0, 0);
        do_op(0, 1, 4'h3, 1);
        do_op(0, 1, 4'h0, 1);
        step(5);
        check("no_err_after_reset", 32'(state), 32'(S_ON));
        do_op(0, 1, 4'hF, 0);
        do_op(1, 0, 4'h0, 0);

        // randomized operation mix
        for (int i = 0; i < 30; i++) begin
            logic [3:0] s;
            int         op;
            op = $urandom_range(0, 3);
            s  = ($urandom_range(0, 2) == 0) ? KEY : 4'($urandom);
            if (op == 0) do_op(1, 0, s, $urandom_range(0, 3));
            else         do_op(0, 1, s, $urandom_range(0, 3));
        end

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) step(1);
        step(3);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
